uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small first-word-fall-through receive FIFO.
// Frame errors and overruns are reported as single-cycle pulses.
//
//  state   | meaning
//  --------+--------------------------------------------------------
//  S_IDLE  | line idle, waiting for a high-to-low transition
//  S_START | half-bit wait, then confirm the start bit is still low
//  S_DATA  | sampling 8 data bits, LSB first, once per bit period
//  S_STOP  | sampling stop bit; high pushes the byte, low flags error
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] CNT_FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] OCC_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          r_sync1, r_sync2, r_rxd_prev;
  logic [1:0]    r_warm;
  logic          w_rxd_s;
  state_t        r_state, w_state_nxt;
  logic [15:0]   r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_push, w_ferr;
  logic          r_frame_err, r_overrun;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_pop, w_full, w_wr;

  assign w_rxd_s = r_sync2;

  // Edge history is held low until both synchronizer stages carry real line
  // samples, so a line stuck low across reset never looks like a start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_warm     <= 2'd0;
      r_rxd_prev <= 1'b0;
    end else begin
      r_sync1    <= rxd;
      r_sync2    <= r_sync1;
      if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
      r_rxd_prev <= (r_warm == 2'd2) ? r_sync2 : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_rxd_prev && !w_rxd_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = CNT_HALF;
        end
      end
      S_START: begin
        if (r_cnt == '0) begin
          if (!w_rxd_s) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = CNT_FULL;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_shift_nxt = {w_rxd_s, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          w_cnt_nxt   = CNT_FULL;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (r_cnt == '0) begin
          w_push      = w_rxd_s;
          w_ferr      = !w_rxd_s;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_pop  = rx_valid && rx_ready;
  assign w_full = (r_count == OCC_FULL);
  // When full, a simultaneous pop frees the slot the write pointer aims at.
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= r_shift;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_push && w_full && !w_pop;
    end
  end

  assign rx_data   = r_mem[r_rptr];
  assign rx_valid  = (r_count != '0);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);

endmodule
